// File: rtl/seq_scan_arb_pkg.sv
// Shared types and constants for the sequence-scan arbiter: FSM states,
// requester count, pattern width and the round-robin pick helper.
package seq_scan_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int PAT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // On a tie the requester holding priority wins; otherwise the lone requester.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] req, input logic prio);
        if (req == 2'b11)
            return prio;
        else
            return req[1];
    endfunction

endpackage

// File: rtl/seq_scan_core.sv
// Bit-serial pattern matcher: 3-bit history, shifted-bit qualifier, hit compare
// and saturating hit counter. SEQ_SCAN_OVERLAP_EN keeps history across hits.
module seq_scan_core
    import seq_scan_arb_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift_en,
    input  logic             last,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [1:0]       QUAL_FULL = 2'(PAT_W - 1);

    logic [PAT_W-2:0] hist_reg;
    logic [1:0]       qual_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] result_reg;
    logic             hit;

    assign hit      = shift_en && (qual_reg == QUAL_FULL) && ({hist_reg, bit_in} == pattern);
    assign cnt_next = (hit && (cnt_reg != CNT_MAX)) ? cnt_reg + 1'b1 : cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_reg   <= '0;
            qual_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else if (start) begin
            hist_reg <= '0;
            qual_reg <= '0;
            cnt_reg  <= '0;
        end else if (shift_en) begin
            cnt_reg <= cnt_next;
            // The published count only moves when a job completes.
            if (last)
                result_reg <= cnt_next;
`ifdef SEQ_SCAN_OVERLAP_EN
            hist_reg <= {hist_reg[PAT_W-3:0], bit_in};
            if (qual_reg != QUAL_FULL)
                qual_reg <= qual_reg + 1'b1;
`else
            if (hit) begin
                hist_reg <= '0;
                qual_reg <= '0;
            end else begin
                hist_reg <= {hist_reg[PAT_W-3:0], bit_in};
                if (qual_reg != QUAL_FULL)
                    qual_reg <= qual_reg + 1'b1;
            end
`endif
        end
    end

    assign match_cnt = result_reg;

endmodule

// File: rtl/seq_scan_arb.sv
// Two-requester round-robin arbiter feeding a serial pattern scanner.
// Build option SEQ_SCAN_OVERLAP_EN selects overlapping hit counting.
module seq_scan_arb
    import seq_scan_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [DATA_W-1:0]  data0,
    input  logic [DATA_W-1:0]  data1,
    input  logic [3:0]         pattern,
    output logic [1:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic               done_id,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int              BC_W     = $clog2(DATA_W);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

    state_t            state_reg;
    logic              owner_reg;
    logic              prio_reg;
    logic              done_id_reg;
    logic [DATA_W-1:0] word_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [BC_W-1:0]   bit_cnt_reg;

    logic [DATA_W-1:0] data_arr [NUM_REQ];
    logic              winner;
    logic              grant_start;
    logic              owner_req;
    logic              shift_en;
    logic              last_bit;

    assign data_arr[0] = data0;
    assign data_arr[1] = data1;

    assign winner      = rr_pick(req, prio_reg);
    assign grant_start = (state_reg == ST_IDLE) && (|req);
    assign owner_req   = req[owner_reg];
    assign shift_en    = (state_reg == ST_SHIFT) && owner_req;
    assign last_bit    = (bit_cnt_reg == LAST_BIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= 1'b0;
            prio_reg    <= 1'b0;
            done_id_reg <= 1'b0;
            word_reg    <= '0;
            pat_reg     <= '0;
            bit_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        owner_reg   <= winner;
                        prio_reg    <= ~winner;
                        word_reg    <= data_arr[winner];
                        pat_reg     <= pattern;
                        bit_cnt_reg <= '0;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Losing the granted request abandons the job without a result.
                    if (!owner_req) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        word_reg    <= {word_reg[DATA_W-2:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        if (last_bit) begin
                            state_reg   <= ST_DONE;
                            done_id_reg <= owner_reg;
                        end
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = (state_reg != ST_IDLE) && (owner_reg == 1'(gi));
        end
    endgenerate

    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign done_id = done_id_reg;

    seq_scan_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (grant_start),
        .shift_en  (shift_en),
        .last      (last_bit),
        .bit_in    (word_reg[DATA_W-1]),
        .pattern   (pat_reg),
        .match_cnt (match_cnt)
    );

endmodule
